inst_loader: RTL and testbench

- Boot-time writer for the instruction memory that the core fetches from.
- Accepts a byte stream over a valid/ready handshake and assembles 9-bit instructions from byte pairs.
- Writes the instructions sequentially from address 0 and holds the core in reset until the image is complete.
- Sits between the bench/host byte source and the instruction memory write port; drives the core's hold input.

---
 rtl/inst_loader.sv | 165 ++++++++++++++++
 tb/tb_inst_loader.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_loader.sv
// rtl/inst_loader.sv - boot-time instruction memory loader; optional trailing checksum via INST_LOADER_CHECKSUM_EN
module inst_loader #(
   parameter int IW = 8,
   parameter int DW = 9
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          in_valid,
   input  logic [7:0]    in_data,
   output logic          in_ready,
   input  logic          load_req,
   output logic          wr_en,
   output logic [IW-1:0] wr_addr,
   output logic [DW-1:0] wr_data,
   output logic          core_hold,
   output logic          loaded,
   output logic          err,
   output logic [IW:0]   words_loaded
);
   localparam int CW = IW + 1;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_LO   = 3'd1,
      S_HI   = 3'd2,
      S_WR   = 3'd3,
      S_DONE = 3'd4
`ifdef INST_LOADER_CHECKSUM_EN
      ,
      S_CK   = 3'd5,
      S_FAIL = 3'd6
`endif
   } state_t;

   state_t        state;
   state_t        next_state;
   logic          armed;       // holds in_ready low until the first clock after reset
   logic [7:0]    lo_byte;
   logic [CW-1:0] n_words;
   logic          accept;
   logic          last_word;
`ifdef INST_LOADER_CHECKSUM_EN
   logic [7:0]    sum;
   logic          hi_bad;
   logic          ck_ok;

   assign ck_ok = (in_data == sum) && !hi_bad;
`endif

   assign accept    = in_valid && in_ready;
   assign last_word = (words_loaded + CW'(1)) == n_words;

   // state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= S_IDLE;
      else        state <= next_state;
   end

   // next-state decode and state-derived outputs
   always_comb begin
      next_state = state;
      in_ready   = 1'b0;
      core_hold  = 1'b1;
      loaded     = 1'b0;
      case (state)
         S_IDLE: begin
            in_ready = armed;
            if (accept) next_state = S_LO;
         end
         S_LO: begin
            in_ready = armed;
            if (accept) next_state = S_HI;
         end
         S_HI: begin
            in_ready = armed;
            if (accept) next_state = S_WR;
         end
         S_WR: begin
`ifdef INST_LOADER_CHECKSUM_EN
            next_state = last_word ? S_CK : S_LO;
`else
            next_state = last_word ? S_DONE : S_LO;
`endif
         end
         S_DONE: begin
            core_hold = 1'b0;
            loaded    = 1'b1;
            if (load_req) next_state = S_IDLE;
         end
`ifdef INST_LOADER_CHECKSUM_EN
         S_CK: begin
            in_ready = armed;
            if (accept) next_state = ck_ok ? S_DONE : S_FAIL;
         end
         S_FAIL: begin
            if (load_req) next_state = S_IDLE;
         end
`endif
         default: next_state = S_IDLE;
      endcase
   end

   // byte assembly, write port, counters and sticky error
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         armed        <= 1'b0;
         lo_byte      <= '0;
         n_words      <= '0;
         wr_en        <= 1'b0;
         wr_addr      <= '0;
         wr_data      <= '0;
         err          <= 1'b0;
         words_loaded <= '0;
`ifdef INST_LOADER_CHECKSUM_EN
         sum          <= '0;
         hi_bad       <= 1'b0;
`endif
      end else begin
         armed <= 1'b1;
         wr_en <= 1'b0;
         case (state)
            S_IDLE: if (accept) begin
               n_words      <= (in_data == 8'd0) ? CW'(1 << IW) : CW'(in_data);
               wr_addr      <= '0;
               words_loaded <= '0;
`ifdef INST_LOADER_CHECKSUM_EN
               sum          <= in_data;
               hi_bad       <= 1'b0;
`endif
            end
            S_LO: if (accept) begin
               lo_byte <= in_data;
`ifdef INST_LOADER_CHECKSUM_EN
               sum     <= sum + in_data;
`endif
            end
            S_HI: if (accept) begin
               wr_data <= DW'({in_data[0], lo_byte});
               wr_en   <= 1'b1;
               if (|in_data[7:1]) err <= 1'b1;
`ifdef INST_LOADER_CHECKSUM_EN
               sum     <= sum + in_data;
               if (|in_data[7:1]) hi_bad <= 1'b1;
`endif
            end
            S_WR: begin
               wr_addr      <= wr_addr + 1'b1;
               words_loaded <= words_loaded + 1'b1;
            end
            S_DONE: if (load_req) begin
               err          <= 1'b0;
               words_loaded <= '0;
            end
`ifdef INST_LOADER_CHECKSUM_EN
            S_CK: if (accept && !ck_ok) err <= 1'b1;
            S_FAIL: if (load_req) begin
               err          <= 1'b0;
               words_loaded <= '0;
            end
`endif
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_inst_loader.sv
// tb/tb_inst_loader.sv - randomized self-checking bench for inst_loader
`timescale 1ns/1ps
module tb_inst_loader;
`ifdef INST_LOADER_CHECKSUM_EN
   localparam bit CK_EN = 1'b1;
`else
   localparam bit CK_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       in_valid = 1'b0;
   logic [7:0] in_data = 8'h00;
   logic       in_ready;
   logic       load_req = 1'b0;
   logic       wr_en;
   logic [7:0] wr_addr;
   logic [8:0] wr_data;
   logic       core_hold;
   logic       loaded;
   logic       err;
   logic [8:0] words_loaded;

   int n_cmp = 0;
   int n_bad = 0;

   logic [7:0] lo_q[$];
   logic [7:0] hi_q[$];
   logic [7:0] cap_addr[$];
   logic [8:0] cap_data[$];

   inst_loader #(.IW(8), .DW(9)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .load_req(load_req), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_data(wr_data), .core_hold(core_hold), .loaded(loaded), .err(err),
      .words_loaded(words_loaded)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (wr_en === 1'b1) begin
         cap_addr.push_back(wr_addr);
         cap_data.push_back(wr_data);
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
      $fatal(1, "watchdog");
   end

   task automatic send_byte(input logic [7:0] b, input int glo, input int ghi);
      int  budget;
      bit  acc;
      repeat ($urandom_range(ghi, glo)) begin @(posedge clk); #1; end
      in_valid = 1'b1;
      in_data  = b;
      acc      = 1'b0;
      budget   = 0;
      while (!acc) begin
         @(negedge clk);
         acc = (in_ready === 1'b1);
         @(posedge clk); #1;
         budget++;
         if (!acc && budget > 20) begin
            n_cmp++; n_bad++;
            $display("FAIL byte_accept: in_ready=%b for 20 cycles, required 1", in_ready);
            acc = 1'b1;
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic reload();
      load_req = 1'b1;
      @(posedge clk); #1;
      load_req = 1'b0;
   endtask

   // Sends count + pairs (+ checksum when enabled) and checks writes and end status
   task automatic run_image(input int n, input int glo, input int ghi, input bit bad_ck);
      logic [7:0] sum;
      bit         hi_err;
      bit         exp_ok;
      bit         exp_err;
      cap_addr.delete();
      cap_data.delete();
      sum    = 8'(n);
      hi_err = 1'b0;
      send_byte(8'(n), glo, ghi);
      for (int i = 0; i < n; i++) begin
         send_byte(lo_q[i], glo, ghi);
         send_byte(hi_q[i], glo, ghi);
         sum = sum + lo_q[i] + hi_q[i];
         if (hi_q[i][7:1] != 7'd0) hi_err = 1'b1;
      end
      n_cmp++;
      if ({loaded, core_hold} !== 2'b01) begin
         n_bad++;
         $display("FAIL early_release: loaded/core_hold=%b, required 01", {loaded, core_hold});
      end
      if (CK_EN) send_byte(bad_ck ? (sum ^ 8'h5A) : sum, glo, ghi);
      else begin @(posedge clk); #1; end
      exp_ok  = !(CK_EN && (hi_err || bad_ck));
      exp_err = hi_err || (CK_EN && bad_ck);
      n_cmp++;
      if (cap_addr.size() != n) begin
         n_bad++;
         $display("FAIL write_count: got %0d writes, required %0d", cap_addr.size(), n);
      end else begin
         for (int i = 0; i < n; i++) begin
            n_cmp++;
            if ({cap_addr[i], cap_data[i]} !== {8'(i), hi_q[i][0], lo_q[i]}) begin
               n_bad++;
               $display("FAIL write_%0d: got addr=%h data=%h, required addr=%h data=%h",
                        i, cap_addr[i], cap_data[i], 8'(i), {hi_q[i][0], lo_q[i]});
            end
         end
      end
      n_cmp++;
      if ({loaded, core_hold, err, words_loaded} !== {exp_ok, !exp_ok, exp_err, 9'(n)}) begin
         n_bad++;
         $display("FAIL status: got loaded=%b hold=%b err=%b words=%0d, required %b %b %b %0d",
                  loaded, core_hold, err, words_loaded, exp_ok, !exp_ok, exp_err, n);
      end
   endtask

   task automatic test_reset();
      #3 reset = 1'b0;
      #1;
      n_cmp++;
      if ({in_ready, wr_en, wr_addr, wr_data, core_hold, loaded, err, words_loaded} !==
          {1'b0, 1'b0, 8'h00, 9'h000, 1'b1, 1'b0, 1'b0, 9'h000}) begin
         n_bad++;
         $display("FAIL reset_outputs: rdy=%b we=%b a=%h d=%h hold=%b ld=%b err=%b w=%0d, required 0 0 00 000 1 0 0 0",
                  in_ready, wr_en, wr_addr, wr_data, core_hold, loaded, err, words_loaded);
      end
      repeat (3) @(posedge clk);
      @(negedge clk); reset = 1'b1;
      @(posedge clk); #1;
      n_cmp++;
      if (in_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL ready_after_reset: in_ready=%b, required 1", in_ready);
      end
   endtask

   task automatic test_basic();
      lo_q = '{8'h34, 8'h7F};
      hi_q = '{8'h01, 8'h00};
      run_image(2, 0, 0, 1'b0);
      reload();
   endtask

   task automatic test_toggle();
      lo_q = '{8'h34, 8'h7F};
      hi_q = '{8'h01, 8'h00};
      run_image(2, 1, 1, 1'b0);
      reload();
   endtask

   task automatic test_full();
      lo_q.delete(); hi_q.delete();
      for (int i = 0; i < 256; i++) begin
         lo_q.push_back(8'($urandom));
         hi_q.push_back(8'($urandom_range(0, 1)));
      end
      run_image(256, 0, 0, 1'b0);
      n_cmp++;
      if (wr_addr !== 8'h00) begin
         n_bad++;
         $display("FAIL full_wrap: wr_addr=%h, required 00", wr_addr);
      end
      reload();
   endtask

   task automatic test_hi_err();
      lo_q = '{8'hA5};
      hi_q = '{8'h03};
      run_image(1, 0, 1, 1'b0);
      reload();
   endtask

   task automatic test_load_req();
      lo_q = '{8'h11, 8'h22, 8'h33};
      hi_q = '{8'h80, 8'h01, 8'h00};
      run_image(3, 0, 0, 1'b0);
      reload();
      n_cmp++;
      if ({core_hold, loaded, err, words_loaded, in_ready} !== {1'b1, 1'b0, 1'b0, 9'd0, 1'b1}) begin
         n_bad++;
         $display("FAIL reload: hold=%b ld=%b err=%b w=%0d rdy=%b, required 1 0 0 0 1",
                  core_hold, loaded, err, words_loaded, in_ready);
      end
   endtask

   task automatic test_midload_reset();
      int n_before;
      cap_addr.delete(); cap_data.delete();
      send_byte(8'd3, 0, 0);
      send_byte(8'h55, 0, 0);
      send_byte(8'h01, 0, 0);
      send_byte(8'h66, 0, 0);
      n_cmp++;
      if (words_loaded !== 9'd1) begin
         n_bad++;
         $display("FAIL midload_count: words_loaded=%0d, required 1", words_loaded);
      end
      #2 reset = 1'b0;
      #1;
      n_cmp++;
      if ({core_hold, wr_en, words_loaded, in_ready, loaded} !== {1'b1, 1'b0, 9'd0, 1'b0, 1'b0}) begin
         n_bad++;
         $display("FAIL midload_reset: hold=%b we=%b w=%0d rdy=%b ld=%b, required 1 0 0 0 0",
                  core_hold, wr_en, words_loaded, in_ready, loaded);
      end
      n_before = cap_addr.size();
      repeat (4) @(posedge clk);
      n_cmp++;
      if (cap_addr.size() != n_before || n_before != 1) begin
         n_bad++;
         $display("FAIL midload_writes: got %0d writes, required 1", cap_addr.size());
      end
      @(negedge clk); reset = 1'b1;
      @(posedge clk); #1;
      lo_q = '{8'hC3, 8'h3C};
      hi_q = '{8'h00, 8'h01};
      run_image(2, 0, 2, 1'b0);
      reload();
   endtask

   task automatic test_random();
      int n;
      for (int k = 0; k < 8; k++) begin
         n = $urandom_range(1, 9);
         lo_q.delete(); hi_q.delete();
         for (int i = 0; i < n; i++) begin
            lo_q.push_back(8'($urandom));
            if ($urandom_range(0, 5) == 0) hi_q.push_back(8'($urandom));
            else                           hi_q.push_back(8'($urandom_range(0, 1)));
         end
         run_image(n, 0, 2, 1'($urandom_range(0, 1)));
         reload();
      end
   endtask

   task automatic test_checksum();
      lo_q = '{8'h10};
      hi_q = '{8'h00};
      run_image(1, 0, 0, 1'b0);
      reload();
      run_image(1, 0, 0, 1'b1);
      reload();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_toggle();
      test_full();
      test_hi_err();
      test_load_req();
      test_midload_reset();
      test_random();
      test_checksum();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
